bmem_rd_arbiter: RTL and testbench
==================================

Name: bmem_rd_arbiter

Overview:
- Arbitrates the single read port (port A) of the 16-bit block memory between two requesters:
  - the display path (BMEM2VGA feeding the SDRAM frame buffer);
  - the compute path (NN accelerator / CPU reading the captured frame).
- Sits between the requesters and bmem port A, and is clocked by the bmem clock.
- Blocks new grants while IPSM is writing a frame, so readers never see a half-written image.
- Display has priority; a starvation counter guarantees compute progress.

Parameters:
- ADDR_W, 11, bmem port A address width.
- DATA_W, 16, bmem port A data width.
- BURST_MAX, 16, maximum beats per grant before forced release (≥1).
- STARVE_LIM, 64, number of waiting cycles after which compute beats display in arbitration (≥1).

Ports:
- iCLK  in  1  bmem clock; all logic on its rising edge.
- iRST  in  1  synchronous, active-high reset.
- iWR_ACTIVE  in  1  high while IPSM writes bmem port B; blocks new grants.
- iD_REQ  in  1  display requests / holds a burst.
- iD_ADDR  in  ADDR_W  display read address for the current beat.
- iD_LAST  in  1  display's current beat is its final beat.
- oD_GNT  out  1  display owns the port.
- oD_RVALID  out  1  display read data valid.
- iC_REQ, iC_ADDR, iC_LAST, oC_GNT, oC_RVALID: same as the display set, for compute.
- oRDATA  out  DATA_W  read data, shared by both requesters; qualified by the RVALID bits.
- oREN  out  1  bmem rden_a.
- oADDR  out  ADDR_W  bmem address_a.
- iQ  in  DATA_W  bmem q_a; valid 1 cycle after an oREN cycle.
- oBUSY  out  1  state ≠ IDLE.

Behaviour:
- Reset (iRST=1 at an edge): state=IDLE.
  - All GNT, RVALID, oREN, oBUSY outputs = 0.
  - oADDR = 0, oRDATA = 0, beat counter = 0, starve counter = 0.
  - Reset mid-burst abandons the burst; any in-flight data is dropped (no RVALID).
- States: IDLE, OWN_D, OWN_C.
  - oD_GNT = (state==OWN_D) and oC_GNT = (state==OWN_C); both registered, never both high.
- IDLE arbitration, evaluated each cycle:
  - If iWR_ACTIVE=1: stay in IDLE.
  - Else if iC_REQ and starve ≥ STARVE_LIM: go to OWN_C.
  - Else if iD_REQ: go to OWN_D.
  - Else if iC_REQ: go to OWN_C.
  - Else stay in IDLE.
  - Every grant spends at least one IDLE cycle before the next grant; this arbitration bubble is the required behaviour.
- Beat acceptance in OWN_X: a beat is accepted in a cycle where iX_REQ=1.
  - That cycle, combinationally: oREN=1, oADDR=iX_ADDR.
  - beat counter += 1.
  - In other cycles oREN=0 and oADDR holds its last value.
- Read return:
  - oX_RVALID pulses for 1 cycle, exactly 1 cycle after the accepted beat.
  - In that same cycle oRDATA = iQ, registered; oRDATA holds between valids.
  - Data of the last beat returns after release; RVALID still goes to the original owner, tracked by a registered owner tag.
- Release, OWN_X → IDLE at the end of any cycle where:
  - an accepted beat has iX_LAST=1; or
  - an accepted beat makes beat count == BURST_MAX; or
  - iX_REQ=0 (requester withdrew).
  - The beat counter clears on release.
- iWR_ACTIVE rising during a burst does not truncate it; only new grants are blocked.
- Starve counter:
  - Increments, saturating at STARVE_LIM, in each cycle where iC_REQ=1 and state≠OWN_C.
  - Clears when state enters OWN_C.
  - Holds when iC_REQ=0.
- Address/data pass straight through with no arithmetic; widths match by parameter.

Test Plan:
1. Reset, then iD_REQ held with addresses 0..3 and iD_LAST on addr 3.
   - oD_GNT rises 1 cycle after the request; oREN on 4 consecutive cycles with oADDR 0,1,2,3.
   - oD_RVALID on the 4 following cycles with oRDATA = mem[0..3]; back to IDLE.
2. Both requesters asserted from IDLE.
   - Display granted first.
   - After its burst ends: 1 IDLE cycle, then oC_GNT=1.
3. Display requests continuously, never asserting LAST; compute requests continuously.
   - Display bursts cap at 16 beats.
   - Compute is granted once starve reaches 64 (after ≤ 64 cycles + 16 beats + bubble).
4. iWR_ACTIVE=1 with both requesters asserted.
   - No GNT and no oREN for the whole window.
   - First grant 1 cycle after iWR_ACTIVE falls; iWR_ACTIVE raised mid-burst lets the burst finish.
5. Compute drops iC_REQ after 2 of 5 beats.
   - Release the next cycle: 2 oC_RVALID pulses, beat counter = 0.
   - Then assert iRST mid display burst: all outputs 0 at the next edge, no stray RVALID.

Source files
------------

// File: rtl/bmem_rd_arbiter.sv
// Read-port arbiter for bmem port A: display has priority, compute is protected by a
// starvation counter, and new grants are held off while a frame is being written.
module bmem_rd_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int BURST_MAX  = 16,
    parameter int STARVE_LIM = 64
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iWR_ACTIVE,
    input  logic              iD_REQ,
    input  logic [ADDR_W-1:0] iD_ADDR,
    input  logic              iD_LAST,
    output logic              oD_GNT,
    output logic              oD_RVALID,
    input  logic              iC_REQ,
    input  logic [ADDR_W-1:0] iC_ADDR,
    input  logic              iC_LAST,
    output logic              oC_GNT,
    output logic              oC_RVALID,
    output logic [DATA_W-1:0] oRDATA,
    output logic              oREN,
    output logic [ADDR_W-1:0] oADDR,
    input  logic [DATA_W-1:0] iQ,
    output logic              oBUSY
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, OWN_D, OWN_C} state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt;
    logic [SW-1:0]     starve;
    logic              own_req, own_last, accept, burst_full, release_now;
    logic [ADDR_W-1:0] own_addr, addr_hold;
    logic              rvalid_d, rvalid_c;
    logic [DATA_W-1:0] rdata_hold;

    // Select the current owner's request signals.
    always_comb begin
        own_req  = 1'b0;
        own_addr = iD_ADDR;
        own_last = 1'b0;
        case (state)
            OWN_D: begin
                own_req  = iD_REQ;
                own_addr = iD_ADDR;
                own_last = iD_LAST;
            end
            OWN_C: begin
                own_req  = iC_REQ;
                own_addr = iC_ADDR;
                own_last = iC_LAST;
            end
            default: begin
                own_req  = 1'b0;
                own_addr = iD_ADDR;
                own_last = 1'b0;
            end
        endcase
        accept      = own_req;
        burst_full  = (beat_cnt == BW'(BURST_MAX - 1));
        release_now = (state != IDLE) && (!own_req || own_last || burst_full);
    end

    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!iWR_ACTIVE) begin
                    if (iC_REQ && (starve >= SW'(STARVE_LIM)))
                        state_nxt = OWN_C;
                    else if (iD_REQ)
                        state_nxt = OWN_D;
                    else if (iC_REQ)
                        state_nxt = OWN_C;
                end
            end
            OWN_D, OWN_C: begin
                if (release_now)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            beat_cnt <= '0;
            starve   <= '0;
        end else begin
            if (release_now)
                beat_cnt <= '0;
            else if (accept)
                beat_cnt <= beat_cnt + BW'(1);

            if ((state != OWN_C) && (state_nxt == OWN_C))
                starve <= '0;
            else if (iC_REQ && (state != OWN_C) && (starve < SW'(STARVE_LIM)))
                starve <= starve + SW'(1);
        end
    end

    // The registered valid bits double as the owner tag for data returning after release.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            addr_hold  <= '0;
            rvalid_d   <= 1'b0;
            rvalid_c   <= 1'b0;
            rdata_hold <= '0;
        end else begin
            if (accept)
                addr_hold <= own_addr;
            rvalid_d <= accept && (state == OWN_D);
            rvalid_c <= accept && (state == OWN_C);
            if (rvalid_d || rvalid_c)
                rdata_hold <= iQ;
        end
    end

    always_comb begin
        oD_GNT    = (state == OWN_D);
        oC_GNT    = (state == OWN_C);
        oBUSY     = (state != IDLE);
        oREN      = accept;
        oADDR     = accept ? own_addr : addr_hold;
        oD_RVALID = rvalid_d;
        oC_RVALID = rvalid_c;
        oRDATA    = (rvalid_d || rvalid_c) ? iQ : rdata_hold;
    end

endmodule

// File: tb/tb_bmem_rd_arbiter.sv
// Directed bench for bmem_rd_arbiter: a cycle model of the arbitration rules checked on
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_bmem_rd_arbiter;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int BURST_MAX  = 16;
    localparam int STARVE_LIM = 64;

    logic              iCLK = 1'b0;
    logic              iRST, iWR_ACTIVE;
    logic              iD_REQ, iD_LAST, iC_REQ, iC_LAST;
    logic [ADDR_W-1:0] iD_ADDR, iC_ADDR;
    logic [DATA_W-1:0] iQ;
    logic              oD_GNT, oD_RVALID, oC_GNT, oC_RVALID, oREN, oBUSY;
    logic [DATA_W-1:0] oRDATA;
    logic [ADDR_W-1:0] oADDR;

    int total = 0;
    int bad   = 0;

    always #5 iCLK = ~iCLK;

    bmem_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iWR_ACTIVE(iWR_ACTIVE),
        .iD_REQ(iD_REQ), .iD_ADDR(iD_ADDR), .iD_LAST(iD_LAST),
        .oD_GNT(oD_GNT), .oD_RVALID(oD_RVALID),
        .iC_REQ(iC_REQ), .iC_ADDR(iC_ADDR), .iC_LAST(iC_LAST),
        .oC_GNT(oC_GNT), .oC_RVALID(oC_RVALID),
        .oRDATA(oRDATA), .oREN(oREN), .oADDR(oADDR), .iQ(iQ), .oBUSY(oBUSY)
    );

    function automatic logic [DATA_W-1:0] memval(input logic [ADDR_W-1:0] a);
        return 16'h5000 + {5'd0, a} * 16'd3;
    endfunction

    // Synchronous-read memory; garbage on q when not read, so unqualified data shows up.
    always @(posedge iCLK) iQ <= oREN ? memval(oADDR) : 16'hDEAD;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic wr,
                                 input logic dreq, input logic [ADDR_W-1:0] daddr, input logic dlast,
                                 input logic creq, input logic [ADDR_W-1:0] caddr, input logic clast);
        @(posedge iCLK);
        #1;
        iRST = rst; iWR_ACTIVE = wr;
        iD_REQ = dreq; iD_ADDR = daddr; iD_LAST = dlast;
        iC_REQ = creq; iC_ADDR = caddr; iC_LAST = clast;
        @(negedge iCLK);
    endtask

    // Behavioural model: owner 0=none 1=display 2=compute.
    int                m_own = 0, m_beats = 0, m_starve = 0, m_pend_owner = 0;
    logic [ADDR_W-1:0] m_pend_addr = '0, m_last_addr = '0;
    logic [DATA_W-1:0] m_last_data = '0;
    bit                m_valid = 0;

    always @(posedge iCLK) begin : mstep
        int nxt;
        logic req, lst, acc;
        logic [ADDR_W-1:0] a;
        if (iRST === 1'b1) begin
            m_own = 0; m_beats = 0; m_starve = 0; m_pend_owner = 0;
            m_last_addr = '0; m_last_data = '0; m_valid = 1;
        end else if (m_valid) begin
            req = (m_own == 1) ? iD_REQ  : ((m_own == 2) ? iC_REQ  : 1'b0);
            lst = (m_own == 1) ? iD_LAST : ((m_own == 2) ? iC_LAST : 1'b0);
            a   = (m_own == 1) ? iD_ADDR : iC_ADDR;
            acc = (m_own != 0) && req;
            if (m_pend_owner != 0) m_last_data = memval(m_pend_addr);
            nxt = m_own;
            if (m_own == 0) begin
                if (!iWR_ACTIVE) begin
                    if (iC_REQ && m_starve >= STARVE_LIM) nxt = 2;
                    else if (iD_REQ) nxt = 1;
                    else if (iC_REQ) nxt = 2;
                end
            end else begin
                if (acc) m_beats++;
                if (!req || lst || m_beats == BURST_MAX) begin
                    nxt = 0;
                    m_beats = 0;
                end
            end
            if (nxt == 2 && m_own != 2) m_starve = 0;
            else if (iC_REQ && m_own != 2 && m_starve < STARVE_LIM) m_starve++;
            m_pend_owner = acc ? m_own : 0;
            if (acc) begin
                m_pend_addr = a;
                m_last_addr = a;
            end
            m_own = nxt;
        end
    end

    always @(negedge iCLK) if (m_valid) begin : cmp
        logic e_ren;
        logic [ADDR_W-1:0] e_addr;
        e_ren  = (m_own == 1 && iD_REQ === 1'b1) || (m_own == 2 && iC_REQ === 1'b1);
        e_addr = !e_ren ? m_last_addr : ((m_own == 1) ? iD_ADDR : iC_ADDR);
        checkOutput("m_d_gnt", oD_GNT, m_own == 1);
        checkOutput("m_c_gnt", oC_GNT, m_own == 2);
        checkOutput("m_busy", oBUSY, m_own != 0);
        checkOutput("m_ren", oREN, e_ren);
        checkOutput("m_addr", oADDR, e_addr);
        checkOutput("m_d_rvalid", oD_RVALID, m_pend_owner == 1);
        checkOutput("m_c_rvalid", oC_RVALID, m_pend_owner == 2);
        checkOutput("m_rdata", oRDATA, (m_pend_owner != 0) ? memval(m_pend_addr) : m_last_data);
    end

    initial begin
        logic [DATA_W-1:0] exp1 [4];
        int first_c, run, max_run, cnt_rv, cnt_gnt, cnt_ren;
        exp1 = '{16'h5000, 16'h5003, 16'h5006, 16'h5009};
        iRST = 1'b1; iWR_ACTIVE = 1'b0;
        iD_REQ = 1'b0; iD_ADDR = '0; iD_LAST = 1'b0;
        iC_REQ = 1'b0; iC_ADDR = '0; iC_LAST = 1'b0;

        // Scenario 1: reset, then a 4-beat display burst.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rst_busy", oBUSY, 0);
        checkOutput("t1_rst_addr", oADDR, 0);
        checkOutput("t1_rst_rdata", oRDATA, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t1_no_gnt_yet", oD_GNT, 0);
        for (int a = 0; a < 4; a++) begin
            applyStimulus(0, 0, 1, 11'(a), a == 3, 0, 0, 0);
            checkOutput("t1_gnt", oD_GNT, 1);
            checkOutput("t1_ren", oREN, 1);
            checkOutput("t1_addr", oADDR, a);
            if (a > 0) begin
                checkOutput("t1_rvalid", oD_RVALID, 1);
                checkOutput("t1_rdata", oRDATA, exp1[a-1]);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_last_rvalid", oD_RVALID, 1);
        checkOutput("t1_last_rdata", oRDATA, exp1[3]);
        checkOutput("t1_released", oD_GNT, 0);

        // Scenario 2: both request; display first, one bubble, then compute.
        applyStimulus(0, 0, 1, 11'h20, 0, 1, 11'h100, 0);
        checkOutput("t2_idle", oBUSY, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 11'(32 + k), k == 2, 1, 11'h100, 0);
            checkOutput("t2_d_first", oD_GNT, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 11'h100, 0);
        checkOutput("t2_bubble", oBUSY, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 11'h100, 0);
        checkOutput("t2_c_gnt", oC_GNT, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 11'h101, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Scenario 3: continuous display vs compute; starvation hands compute the port.
        first_c = -1; run = 0; max_run = 0;
        for (int i = 0; i < 150 && first_c < 0; i++) begin
            applyStimulus(0, 0, 1, 11'(i), 0, 1, 11'h300, 1);
            if (oD_GNT) begin
                run++;
                if (run > max_run) max_run = run;
            end else run = 0;
            if (oC_GNT) first_c = i;
        end
        checkOutput("t3_first_c_gnt", first_c, 69);
        checkOutput("t3_d_burst_len", max_run, 16);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Scenario 4: writer blocks new grants but not a running burst.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 1, 11'h10, 0, 1, 11'h400, 0);
            checkOutput("t4_no_gnt", oD_GNT | oC_GNT, 0);
            checkOutput("t4_no_ren", oREN, 0);
        end
        applyStimulus(0, 0, 1, 11'h10, 0, 1, 11'h400, 0);
        checkOutput("t4_fall_cycle", oBUSY, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 1, 11'(16 + k), k == 3, 1, 11'h400, 0);
            checkOutput("t4_burst_runs", oD_GNT, 1);
        end
        applyStimulus(0, 1, 0, 0, 0, 1, 11'h400, 0);
        checkOutput("t4_blocked_a", oBUSY, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 11'h400, 0);
        checkOutput("t4_blocked_b", oBUSY, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Scenario 5: compute withdraws after two beats, then a full capped burst.
        applyStimulus(0, 0, 0, 0, 0, 1, 11'h200, 0);
        cnt_rv = 0;
        applyStimulus(0, 0, 0, 0, 0, 1, 11'h200, 0);
        cnt_rv += int'(oC_RVALID);
        applyStimulus(0, 0, 0, 0, 0, 1, 11'h201, 0);
        cnt_rv += int'(oC_RVALID);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cnt_rv += int'(oC_RVALID);
        checkOutput("t5_withdraw_gnt", oC_GNT, 1);
        checkOutput("t5_withdraw_ren", oREN, 0);
        checkOutput("t5_rdata", oRDATA, 16'h5603);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cnt_rv += int'(oC_RVALID);
        checkOutput("t5_rvalid_count", cnt_rv, 2);
        cnt_gnt = 0; cnt_ren = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 11'(528 + i), 0);
            cnt_gnt += int'(oC_GNT);
            cnt_ren += int'(oREN);
        end
        checkOutput("t5_cap_gnt", cnt_gnt, 16);
        checkOutput("t5_cap_ren", cnt_ren, 16);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a display burst drops the in-flight beat.
        applyStimulus(0, 0, 1, 11'h50, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 11'h50, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 11'h51, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 11'h52, 0, 0, 0, 0);
        checkOutput("t5_pre_rst_ren", oREN, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_rst_gnt", oD_GNT, 0);
        checkOutput("t5_rst_rvalid", oD_RVALID, 0);
        checkOutput("t5_rst_addr", oADDR, 0);
        checkOutput("t5_rst_rdata", oRDATA, 0);
        checkOutput("t5_rst_busy", oBUSY, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_no_stray", oD_RVALID | oC_RVALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
